// File: rtl/ad9783_pkg.sv
// Shared types and constants for the AD9783 SPI configuration controller.
// Contents: FSM state and frame-phase enums, SPI frame geometry, the
// register-init table words, and a helper that builds the instruction byte.
package ad9783_pkg;

  typedef enum logic [2:0] {
    StRstHold,
    StRstWait,
    StInitLoad,
    StFrame,
    StGap,
    StIdle
  } state_t;

  // Sub-phases of one SPI frame: setup, SCK low half, SCK high half, hold.
  typedef enum logic [1:0] {
    PhSetup,
    PhLow,
    PhHigh,
    PhHold
  } phase_t;

  localparam int unsigned SPI_FRAME_BITS = 16;
  localparam int unsigned SPI_RW_BIT     = 7;

  // Init table entries as {instruction, data}; all are writes.
  localparam logic [SPI_FRAME_BITS-1:0] INIT_SPI_CTRL  = {8'h00, 8'h00};  // 4-wire, MSB first
  localparam logic [SPI_FRAME_BITS-1:0] INIT_DATA_CTRL = {8'h02, 8'h00};
  localparam logic [SPI_FRAME_BITS-1:0] INIT_PWR_DOWN  = {8'h03, 8'h00};  // power-down off

  // Instruction byte: R/W in bit 7, two-bit length field fixed to single byte.
  function automatic logic [7:0] make_instr(input logic rd, input logic [4:0] reg_addr);
    return {rd, 2'b00, reg_addr};
  endfunction

endpackage

// File: rtl/ad9783_spi_ctrl_if.sv
// Host command bus of the AD9783 SPI controller.
// master: host side (drives trigger, address, write data).
// slave : controller side (drives read data, busy, done, init_done).
interface ad9783_spi_ctrl_if;
  logic        cmd_trig_in;
  logic [15:0] cmd_addr_in;
  logic [15:0] cmd_data_in;
  logic [15:0] cmd_data_out;
  logic        cmd_busy_out;
  logic        cmd_done_out;
  logic        init_done_out;

  modport master (
    output cmd_trig_in,
    output cmd_addr_in,
    output cmd_data_in,
    input  cmd_data_out,
    input  cmd_busy_out,
    input  cmd_done_out,
    input  init_done_out
  );

  modport slave (
    input  cmd_trig_in,
    input  cmd_addr_in,
    input  cmd_data_in,
    output cmd_data_out,
    output cmd_busy_out,
    output cmd_done_out,
    output init_done_out
  );
endinterface

// File: rtl/ad9783_init_rom.sv
// Combinational init ROM: maps an init index to a 16-bit {instr, data} frame.
// Ports:
//   idx  - init entry index (0..15)
//   word - frame word to shift out
// Indices past the defined table repeat the SPI-control write, which is harmless.
module ad9783_init_rom
  import ad9783_pkg::*;
(
  input  logic [3:0]                idx,
  output logic [SPI_FRAME_BITS-1:0] word
);

  always_comb begin
    word = INIT_SPI_CTRL;
    case (idx)
      4'd0:    word = INIT_SPI_CTRL;
      4'd1:    word = INIT_DATA_CTRL;
      4'd2:    word = INIT_PWR_DOWN;
      default: word = INIT_SPI_CTRL;
    endcase
  end

endmodule

// File: rtl/ad9783_spi_ctrl.sv
// AD9783 SPI configuration controller.
// After reset it pulses the DAC reset, replays the init ROM as write frames,
// then serves single-register host read/write commands as 16-bit SPI frames
// (8-bit instruction, 8-bit data, MSB first, DAC samples on SCK rising edge).
// Ports:
//   clk_in, rst_in   - clock and synchronous active-high reset
//   cmd              - host command bus (slave side of ad9783_spi_ctrl_if)
//   rst_out          - DAC hardware reset, active high
//   spi_scs_out      - chip select, active low
//   spi_sck_out      - serial clock, idle low
//   spi_sdo_out      - serial data to DAC
//   spi_sdi_in       - serial data from DAC
// Build option: define AD9783_SPI_READBACK_EN to include SDI capture and read
// data return; otherwise cmd_data_out is constant zero and spi_sdi_in is unused.
module ad9783_spi_ctrl
  import ad9783_pkg::*;
#(
  parameter int unsigned CLK_DIV    = 4,
  parameter int unsigned RST_CYCLES = 16,
  parameter int unsigned INIT_LEN   = 3
) (
  input  logic               clk_in,
  input  logic               rst_in,
  ad9783_spi_ctrl_if.slave   cmd,
  output logic               rst_out,
  output logic               spi_scs_out,
  output logic               spi_sck_out,
  output logic               spi_sdo_out,
  input  logic               spi_sdi_in
);

  localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned RstW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  state_t                    state_q, state_d;
  phase_t                    phase_q, phase_d;
  logic [DivW-1:0]           div_q, div_d;
  logic [RstW-1:0]           rst_cnt_q, rst_cnt_d;
  logic [3:0]                bit_q, bit_d;
  logic [SPI_FRAME_BITS-1:0] shift_q, shift_d;
  logic [3:0]                idx_q, idx_d;
  logic                      host_q, host_d;
  logic                      init_done_q, init_done_d;
  logic [SPI_FRAME_BITS-1:0] rom_word;
  logic                      div_end, rst_end;

`ifdef AD9783_SPI_READBACK_EN
  logic                      rd_q, rd_d;
  logic [7:0]                rx_q, rx_d;
  logic [15:0]               data_out_q, data_out_d;
`else
  logic                      unused_sdi;
  assign unused_sdi = spi_sdi_in;
`endif

  logic unused_cmd_bits;
  assign unused_cmd_bits = ^{cmd.cmd_addr_in[15:8], cmd.cmd_addr_in[6:5],
                             cmd.cmd_data_in[15:8]};

  ad9783_init_rom u_init_rom (
    .idx  (idx_q),
    .word (rom_word)
  );

  assign div_end = (div_q == DivW'(CLK_DIV - 1));
  assign rst_end = (rst_cnt_q == RstW'(RST_CYCLES - 1));

  // State register.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= StRstHold;
      phase_q     <= PhSetup;
      div_q       <= '0;
      rst_cnt_q   <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      idx_q       <= '0;
      host_q      <= 1'b0;
      init_done_q <= 1'b0;
`ifdef AD9783_SPI_READBACK_EN
      rd_q        <= 1'b0;
      rx_q        <= '0;
      data_out_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      div_q       <= div_d;
      rst_cnt_q   <= rst_cnt_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      idx_q       <= idx_d;
      host_q      <= host_d;
      init_done_q <= init_done_d;
`ifdef AD9783_SPI_READBACK_EN
      rd_q        <= rd_d;
      rx_q        <= rx_d;
      data_out_q  <= data_out_d;
`endif
    end
  end

  // Next-state and datapath.
  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    div_d       = div_q;
    rst_cnt_d   = rst_cnt_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    idx_d       = idx_q;
    host_d      = host_q;
    init_done_d = init_done_q;
`ifdef AD9783_SPI_READBACK_EN
    rd_d        = rd_q;
    rx_d        = rx_q;
    data_out_d  = data_out_q;
`endif

    unique case (state_q)
      StRstHold: begin
        if (rst_end) begin
          rst_cnt_d = '0;
          state_d   = StRstWait;
        end else begin
          rst_cnt_d = rst_cnt_q + 1'b1;
        end
      end

      StRstWait: begin
        if (rst_end) begin
          rst_cnt_d = '0;
          idx_d     = '0;
          state_d   = StInitLoad;
        end else begin
          rst_cnt_d = rst_cnt_q + 1'b1;
        end
      end

      StInitLoad: begin
        shift_d = rom_word;
        host_d  = 1'b0;
`ifdef AD9783_SPI_READBACK_EN
        rd_d    = 1'b0;
`endif
        phase_d = PhSetup;
        div_d   = '0;
        bit_d   = 4'd15;
        state_d = StFrame;
      end

      StIdle: begin
        if (cmd.cmd_trig_in) begin
          // Read frames drive zeros in the data byte.
          shift_d = {make_instr(cmd.cmd_addr_in[SPI_RW_BIT], cmd.cmd_addr_in[4:0]),
                     cmd.cmd_addr_in[SPI_RW_BIT] ? 8'h00 : cmd.cmd_data_in[7:0]};
          host_d  = 1'b1;
`ifdef AD9783_SPI_READBACK_EN
          rd_d    = cmd.cmd_addr_in[SPI_RW_BIT];
`endif
          phase_d = PhSetup;
          div_d   = '0;
          bit_d   = 4'd15;
          state_d = StFrame;
        end
      end

      StFrame: begin
        if (div_end) begin
          div_d = '0;
          unique case (phase_q)
            PhSetup: phase_d = PhLow;
            PhLow: begin
              phase_d = PhHigh;
`ifdef AD9783_SPI_READBACK_EN
              // This edge is the SCK rising edge; capture the data byte bits.
              if (bit_q < 4'd8) rx_d = {rx_q[6:0], spi_sdi_in};
`endif
            end
            PhHigh: begin
              if (bit_q == 4'd0) begin
                phase_d = PhHold;
              end else begin
                bit_d   = bit_q - 1'b1;
                shift_d = {shift_q[SPI_FRAME_BITS-2:0], 1'b0};
                phase_d = PhLow;
              end
            end
            PhHold: begin
              state_d = StGap;
`ifdef AD9783_SPI_READBACK_EN
              if (host_q && rd_q) data_out_d = {8'h00, rx_q};
`endif
            end
            default: phase_d = PhSetup;
          endcase
        end else begin
          div_d = div_q + 1'b1;
        end
      end

      StGap: begin
        if (div_end) begin
          div_d = '0;
          if (init_done_q) begin
            state_d = StIdle;
          end else if (idx_q == 4'(INIT_LEN - 1)) begin
            init_done_d = 1'b1;
            state_d     = StIdle;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = StInitLoad;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end

      default: state_d = StRstHold;
    endcase
  end

  // Outputs decoded from registered state.
  always_comb begin
    rst_out           = (state_q == StRstHold);
    spi_scs_out       = (state_q != StFrame);
    spi_sck_out       = (state_q == StFrame) && (phase_q == PhHigh);
    spi_sdo_out       = (state_q == StFrame) ? shift_q[SPI_FRAME_BITS-1] : 1'b0;
    cmd.cmd_busy_out  = (state_q != StIdle);
    // First gap cycle is the cycle chip select rises.
    cmd.cmd_done_out  = (state_q == StGap) && (div_q == '0) && host_q;
    cmd.init_done_out = init_done_q;
`ifdef AD9783_SPI_READBACK_EN
    cmd.cmd_data_out  = data_out_q;
`else
    cmd.cmd_data_out  = 16'h0000;
`endif
  end

endmodule

// File: doc/ad9783_spi_ctrl.md
Name: ad9783_spi_ctrl

Overview:
SPI configuration controller for the AD9783 DAC. After reset it pulses the DAC hardware reset and replays a fixed register-init sequence. It then accepts single-register read/write commands from the host command bus and serialises each one as a 16-bit SPI frame (8-bit instruction, 8-bit data). It sits beside the AD9783 LVDS datapath and owns the DAC reset and SPI pins.

Parameters:
CLK_DIV, 4, clk_in cycles per SCK half-period (>=2); at 100 MHz gives 12.5 MHz SCK
RST_CYCLES, 16, clk_in cycles rst_out is held high, and the wait after its release
INIT_LEN, 3, number of init-ROM entries replayed after reset (1..16)

Ports:
clk_in  in  1  system clock, 100 MHz
rst_in  in  1  synchronous, active-high reset
cmd_trig_in  in  1  one-cycle command strobe, sampled only when cmd_busy_out=0
cmd_addr_in  in  16  [7]=read(1)/write(0), [4:0]=register address; other bits ignored
cmd_data_in  in  16  [7:0]=write data; other bits ignored
cmd_data_out  out  16  read data, zero-extended, valid from cmd_done_out onward
cmd_busy_out  out  1  high during reset/init, frame and inter-frame gap
cmd_done_out  out  1  one-cycle pulse at end of host frame (not for init frames)
init_done_out  out  1  high once the init sequence has completed
rst_out  out  1  DAC hardware reset, active high
spi_scs_out  out  1  chip select, active low
spi_sck_out  out  1  serial clock, idle low
spi_sdo_out  out  1  serial data to DAC
spi_sdi_in  in  1  serial data from DAC

Behaviour:
- Reset (rst_in=1 at a clk_in edge): scs=1, sck=0, sdo=0, rst_out=1, busy=1, done=0, init_done=0, cmd_data_out=0, state=RST_HOLD. Takes effect on the next edge even mid-frame; the frame is aborted.
- States: RST_HOLD -> RST_WAIT -> INIT_LOAD -> FRAME -> GAP -> (INIT_LOAD | IDLE); IDLE -> FRAME on accepted trigger.
- RST_HOLD: rst_out=1 for RST_CYCLES cycles after rst_in falls. RST_WAIT: rst_out=0, wait RST_CYCLES.
- INIT_LOAD: fetch entry k (k=0..INIT_LEN-1) from ROM as a write frame. After the last GAP: init_done=1, busy=0, IDLE.
- IDLE: cmd_trig_in=1 with busy=0 latches {instr, data}: instr = {cmd_addr_in[7], 2'b00, cmd_addr_in[4:0]}. Busy rises the next cycle. Triggers while busy are dropped with no queueing.
- FRAME: scs falls 1 cycle after accept. Setup phase of CLK_DIV cycles with sdo=bit15. Then 16 SCK periods of 2*CLK_DIV cycles (low half, then high half), MSB first. sdo changes only while sck is low; the DAC samples on the rising edge. Hold phase of CLK_DIV cycles with sck low, then scs rises. scs is low for exactly 34*CLK_DIV cycles.
- Read frames: sdo=0 during data bits 7..0. spi_sdi_in is sampled on each of the last 8 rising SCK edges into a shift register; cmd_data_out updates on the cycle scs rises.
- cmd_done_out pulses on the cycle scs rises (host frames only).
- GAP: scs high and busy=1 for CLK_DIV cycles, then IDLE with busy=0. A trigger in the first idle cycle is accepted.
- Counters: division counter is ceil(log2(CLK_DIV)) bits; bit counter is 4 bits (15 -> 0, no wrap); init index is 4 bits.

Optional Feature:
AD9783_SPI_READBACK_EN. When defined: SDI capture logic is present and read frames update cmd_data_out as above. When undefined: no SDI capture; read frames still shift the instruction with data bits=0, cmd_data_out stays 16'h0000, and spi_sdi_in is unused.

Decomposition:
- Package ad9783_pkg: state enum, SPI_FRAME_BITS=16, SPI_RW_BIT=7, and init-table constants: {0x00,0x00} SPI control (4-wire, MSB first), {0x02,0x00} data control, {0x03,0x00} power-down off.
- Sub-module ad9783_init_rom: combinational index -> 16-bit frame word.

Test Plan:
- Release reset (defaults) -> rst_out high 16 cycles, low 16, then SDO frames 0x0000, 0x0200, 0x0300; init_done=1 and busy=0 after the final gap; no cmd_done pulses.
- Write cmd_addr=0x000A, cmd_data=0x005A -> SDO 0x0A5A MSB first over 16 rising SCK edges; scs low 136 cycles; cmd_done pulses 1 cycle; busy low 4 cycles later.
- Read cmd_addr=0x008A, SDI model returns 0xC3 -> SDO instruction 0x8A then 0x00; cmd_data_out=0x00C3 with the macro, 0x0000 without.
- Second trigger 10 cycles into a frame -> dropped; exactly one frame and one cmd_done pulse.
- rst_in pulsed at bit 8 of a host frame -> next edge scs=1, sck=0, rst_out=1, no cmd_done; full reset/init sequence replays.
- Trigger in the first cycle busy=0 after a frame -> accepted; scs-high gap between frames is exactly CLK_DIV+1 cycles.
